// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone classic controller: response status codes,
// controller FSM states and a counter-width helper.
package wishbone_pkg;

  typedef enum logic [1:0] {
    WB_OK      = 2'd0,
    WB_ERR     = 2'd1,
    WB_RTY     = 2'd2,
    WB_TIMEOUT = 2'd3
  } wb_status_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } wb_ctrl_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wishbone_classic_controller_if.sv
// Request/response stream plus Wishbone classic signals of the controller.
// master = controller view, slave = local logic + Wishbone device view.
interface wishbone_classic_controller_if
  import wishbone_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
) ();

  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  // Both streams transfer on a clock edge where valid and ready are high together;
  // the side raising valid holds it and its payload until that edge.
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [ADR_WIDTH-1:0] req_adr_i;
  logic [SEL_WIDTH-1:0] req_sel_i;
  logic [DAT_WIDTH-1:0] req_dat_i;

  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [DAT_WIDTH-1:0] resp_dat_o;
  wb_status_t           resp_status_o;

  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [SEL_WIDTH-1:0] sel_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;
  logic [DAT_WIDTH-1:0] dat_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i, resp_ready_i,
    input  ack_i, err_i, rty_i, dat_i,
    output req_ready_o, resp_valid_o, resp_dat_o, resp_status_o,
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i, resp_ready_i,
    output ack_i, err_i, rty_i, dat_i,
    input  req_ready_o, resp_valid_o, resp_dat_o, resp_status_o,
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );

endinterface

// File: rtl/wb_down_counter.sv
// Loadable down counter that stops at zero; zero_o flags the registered count.
module wb_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= load_val_i;
    end else if (en_i && (count_o != '0)) begin
      count_o <= count_o - WIDTH'(1);
    end
  end

  assign zero_o = (count_o == '0);

endmodule

// File: rtl/wishbone_classic_controller.sv
// Wishbone B4 classic single-transfer master driven by a valid/ready request stream,
// with retry-with-backoff on rty, a bus timeout and a status-tagged response stream.
module wishbone_classic_controller
  import wishbone_pkg::*;
#(
  parameter int ADR_WIDTH      = 32,
  parameter int DAT_WIDTH      = 32,
  parameter int MAX_RETRIES    = 3,
  parameter int BACKOFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  wishbone_classic_controller_if.master    bus,
  output wb_ctrl_state_t                   state_o
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  localparam int TO_W      = cnt_width(TIMEOUT_CYCLES);
  localparam int BO_W      = cnt_width(BACKOFF_CYCLES);
  localparam int RT_W      = cnt_width(MAX_RETRIES);

  // Loaded with N-1: the counter reaches zero on the N-th cycle spent in the state.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'((BACKOFF_CYCLES < 1) ? 0 : BACKOFF_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

  wb_ctrl_state_t state_q, state_d;
  logic [RT_W-1:0] retry_q, retry_d;

  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DAT_WIDTH-1:0] resp_dat_q, resp_dat_d;
  wb_status_t           resp_status_q, resp_status_d;

  logic            enter_bus, enter_backoff;
  logic            to_zero, bo_zero, timeout_hit;
  logic [TO_W-1:0] to_count;
  logic [BO_W-1:0] bo_count;

  wb_down_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (enter_bus),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == ST_BUS),
    .count_o    (to_count),
    .zero_o     (to_zero)
  );

  wb_down_counter #(.WIDTH(BO_W)) u_backoff_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (enter_backoff),
    .load_val_i (BO_LOAD),
    .en_i       (state_q == ST_BACKOFF),
    .count_o    (bo_count),
    .zero_o     (bo_zero)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && to_zero;

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    adr_d         = adr_q;
    sel_d         = sel_q;
    dat_d         = dat_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_dat_d    = resp_dat_q;
    resp_status_d = resp_status_q;
    enter_bus     = 1'b0;
    enter_backoff = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        // The registered request outputs double as the latch re-issued after rty.
        if (req_ready_q && bus.req_valid_i) begin
          we_d        = bus.req_we_i;
          adr_d       = bus.req_adr_i;
          sel_d       = bus.req_sel_i;
          dat_d       = bus.req_dat_i;
          retry_d     = '0;
          cyc_d       = 1'b1;
          req_ready_d = 1'b0;
          enter_bus   = 1'b1;
          state_d     = ST_BUS;
        end
      end

      ST_BUS: begin
        if (bus.err_i) begin
          cyc_d         = 1'b0;
          resp_valid_d  = 1'b1;
          resp_dat_d    = '0;
          resp_status_d = WB_ERR;
          state_d       = ST_RESP;
        end else if (bus.ack_i) begin
          cyc_d         = 1'b0;
          resp_valid_d  = 1'b1;
          resp_dat_d    = we_q ? '0 : bus.dat_i;
          resp_status_d = WB_OK;
          state_d       = ST_RESP;
        end else if (bus.rty_i) begin
          cyc_d = 1'b0;
          if (retry_q < RT_MAX) begin
            retry_d       = retry_q + RT_W'(1);
            enter_backoff = 1'b1;
            state_d       = ST_BACKOFF;
          end else begin
            resp_valid_d  = 1'b1;
            resp_dat_d    = '0;
            resp_status_d = WB_RTY;
            state_d       = ST_RESP;
          end
        end else if (timeout_hit) begin
          cyc_d         = 1'b0;
          resp_valid_d  = 1'b1;
          resp_dat_d    = '0;
          resp_status_d = WB_TIMEOUT;
          state_d       = ST_RESP;
        end
      end

      ST_BACKOFF: begin
        if (bo_zero) begin
          cyc_d     = 1'b1;
          enter_bus = 1'b1;
          state_d   = ST_BUS;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      sel_q         <= '0;
      dat_q         <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_dat_q    <= '0;
      resp_status_q <= WB_OK;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      dat_q         <= dat_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_dat_q    <= resp_dat_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_dat_o    = resp_dat_q;
  assign bus.resp_status_o = resp_status_q;
  assign bus.cyc_o         = cyc_q;
  assign bus.stb_o         = cyc_q;
  assign bus.we_o          = we_q;
  assign bus.adr_o         = adr_q;
  assign bus.sel_o         = sel_q;
  assign bus.dat_o         = dat_q;
  assign state_o           = state_q;

`ifdef FORMAL
  logic term_w;
  assign term_w = (state_q == ST_BUS) &&
                  (bus.ack_i || bus.err_i || bus.rty_i || timeout_hit);

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (cyc_q && !term_w) |=> (cyc_q && $stable(we_q) && $stable(adr_q) &&
                            $stable(sel_q) && $stable(dat_q)));

  a_cyc_drops: assert property (@(posedge clk_i) disable iff (!rst_i)
    term_w |=> !cyc_q);

  a_resp_after_cycle: assert property (@(posedge clk_i) disable iff (!rst_i)
    $rose(resp_valid_q) |-> $past(cyc_q));
`endif

endmodule
